// File: rtl/apb_arb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_master_if
// Brief    : Requester command/response bundle plus APB master bus for the
//            apb_arb_master block.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_arb_master_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_slverr;
    logic                          rsp_timeout;
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [DATA_WIDTH-1:0]         pwdata;
    logic [DATA_WIDTH-1:0]         prdata;
    logic                          pready;
    logic                          pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_master
// Brief    : Round-robin arbitrated APB master with wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_arb_master #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input wire               pclk,
    input wire               preset,
    apb_arb_master_if.master bus
);
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit c_TO_EN = (TIMEOUT > 0);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDX_W-1:0]      r_last;
    logic [c_IDX_W-1:0]      r_owner;
    logic [c_IDX_W-1:0]      w_win;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_found;
    logic [NUM_REQ-1:0]      w_ready;
    logic [NUM_REQ-1:0]      w_owner_oh;
    logic                    w_accept;
    logic                    w_done_ok;
    logic                    w_done_to;
    logic [c_CNT_W-1:0]      r_wait;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_slverr;
    logic                    r_rsp_timeout;

    // Search starts one past the last grant, so the previous winner ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = c_IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && !preset && w_found) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_owner_oh          = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    assign w_accept  = |w_ready;
    assign w_done_ok = (r_state == S_ACCESS) && bus.pready;
    assign w_done_to = (r_state == S_ACCESS) && !bus.pready && c_TO_EN && (r_wait == c_CNT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_done_ok || w_done_to) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_last        <= c_IDX_W'(NUM_REQ - 1);
            r_owner       <= '0;
            r_wait        <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_last   <= w_win;
                r_owner  <= w_win;
                r_pwrite <= bus.req_write[w_win];
                r_paddr  <= bus.req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                r_pwdata <= bus.req_wdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_state == S_SETUP) begin
                r_wait <= '0;
            end else if (r_state == S_ACCESS && !bus.pready && r_wait != c_CNT_MAX) begin
                r_wait <= r_wait + c_CNT_W'(1);
            end
            // pready has priority over an expiring timeout in the same cycle.
            if (w_done_ok || w_done_to) begin
                r_rsp_valid   <= w_owner_oh;
                r_rsp_rdata   <= (w_done_ok && !r_pwrite) ? bus.prdata : '0;
                r_rsp_slverr  <= w_done_ok ? bus.pslverr : 1'b1;
                r_rsp_timeout <= w_done_to;
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.psel        = (r_state != S_IDLE);
    assign bus.penable     = (r_state == S_ACCESS);
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule
`default_nettype wire
